// File: rtl/fc_pkg.sv
// Shared constants and helpers for the FC engine output stage.
package fc_pkg;

  localparam int RELU_OFF     = 0;
  localparam int RELU_ON      = 1;
  localparam int RELU_RUNTIME = 2;

  // Lane 0 of a tile is loaded on the edge that leaves IDLE, so LOAD is a transition, not a resting state.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Per-lane requantisation: bias add, round-half-up right shift, saturation, optional ReLU.
module fc_requant
  import fc_pkg::*;
#(
  parameter int PSUM_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int BIAS_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [PSUM_WIDTH-1:0]  psum,
  input  logic signed [BIAS_WIDTH-1:0]  bias,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu,
  output logic signed [DATA_WIDTH-1:0]  result
);

  // One guard bit for the bias add and one for the rounding term.
  localparam int AW = PSUM_WIDTH + 2;
  localparam logic signed [AW-1:0] MAX_V = AW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MIN_V = AW'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] sat;
  int                   shift_amt;

  always_comb begin
    acc = {{2{psum[PSUM_WIDTH-1]}}, psum} + {{(AW-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
    // Beyond PSUM_WIDTH+1 every in-range accumulator rounds to zero, so the shift is clamped there.
    shift_amt = (int'(shift) > PSUM_WIDTH + 1) ? PSUM_WIDTH + 1 : int'(shift);
    rnd = '0;
    if (shift_amt != 0) begin
      rnd = AW'(1) << (shift_amt - 1);
    end
    rounded = (acc + rnd) >>> shift_amt;
    sat = rounded;
    if (rounded > MAX_V) begin
      sat = MAX_V;
    end else if (rounded < MIN_V) begin
      sat = MIN_V;
    end
    result = sat[DATA_WIDTH-1:0];
    if (relu && result[DATA_WIDTH-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/fc_tile_drain.sv
// FC engine output stage: ping-pong capture of partial-sum tiles and a one-lane-per-beat
// requantised stream under valid/ready.
module fc_tile_drain
  import fc_pkg::*;
#(
  parameter int PSUM_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int BIAS_WIDTH  = 16,
  parameter int TILING_SIZE = 8,
  parameter int NUM_TILES   = 512,
  parameter int SHIFT_WIDTH = 5,
  parameter int RELU        = 1
) (
  input  logic                                  clk2,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  set_output,
  input  logic [TILING_SIZE*PSUM_WIDTH-1:0]     psum,
  input  logic [TILING_SIZE*BIAS_WIDTH-1:0]     bias,
  input  logic [SHIFT_WIDTH-1:0]                shift,
  input  logic                                  relu_en,
  output logic                                  capture_ready,
  output logic [DATA_WIDTH-1:0]                 ofm,
  output logic                                  ofm_valid,
  input  logic                                  ofm_ready,
  output logic [idx_width(TILING_SIZE)-1:0]     lane_idx,
  output logic                                  tile_done,
  output logic                                  layer_done,
  output logic                                  overrun
);

  localparam int LW = idx_width(TILING_SIZE);
  localparam int TW = idx_width(NUM_TILES);
  localparam logic [LW-1:0] LAST_LANE = LW'(TILING_SIZE - 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  // Bank storage; no reset needed because the full flags gate every read.
  logic [TILING_SIZE*PSUM_WIDTH-1:0] psum_mem  [2];
  logic [TILING_SIZE*BIAS_WIDTH-1:0] bias_mem  [2];
  logic [SHIFT_WIDTH-1:0]            shift_mem [2];
  logic                              relu_mem  [2];

  drain_state_t    state_reg, state_next;
  logic [1:0]      full_reg;
  logic            wr_bank_reg, rd_bank_reg;
  logic [LW-1:0]   lane_reg;
  logic [TW-1:0]   tile_reg;
  logic [DATA_WIDTH-1:0] ofm_reg;
  logic            ofm_valid_reg;
  logic            tile_done_reg, layer_done_reg, overrun_reg;

  logic            relu_eff;
  logic            capture_fire;
  logic            sel_bank;
  logic [LW-1:0]   sel_lane;
  logic            do_load, do_advance, do_release;

  logic signed [PSUM_WIDTH-1:0] lane_psum [TILING_SIZE];
  logic signed [BIAS_WIDTH-1:0] lane_bias [TILING_SIZE];
  logic signed [DATA_WIDTH-1:0] rq_result;

  assign relu_eff      = (RELU == RELU_ON) || ((RELU == RELU_RUNTIME) && relu_en);
  assign capture_ready = ~(full_reg[0] & full_reg[1]);
  assign capture_fire  = set_output && capture_ready && !clear;

  always_ff @(posedge clk2) begin
    if (capture_fire) begin
      psum_mem[wr_bank_reg]  <= psum;
      bias_mem[wr_bank_reg]  <= bias;
      shift_mem[wr_bank_reg] <= shift;
      relu_mem[wr_bank_reg]  <= relu_eff;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TILING_SIZE; gi++) begin : g_lane
      assign lane_psum[gi] = psum_mem[sel_bank][gi*PSUM_WIDTH +: PSUM_WIDTH];
      assign lane_bias[gi] = bias_mem[sel_bank][gi*BIAS_WIDTH +: BIAS_WIDTH];
    end
  endgenerate

  fc_requant #(
    .PSUM_WIDTH  (PSUM_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .BIAS_WIDTH  (BIAS_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant (
    .psum   (lane_psum[sel_lane]),
    .bias   (lane_bias[sel_lane]),
    .shift  (shift_mem[sel_bank]),
    .relu   (relu_mem[sel_bank]),
    .result (rq_result)
  );

  // sel_bank/sel_lane point at the beat that will be registered into ofm on the next edge.
  always_comb begin
    state_next = state_reg;
    sel_bank   = rd_bank_reg;
    sel_lane   = lane_reg;
    do_load    = 1'b0;
    do_advance = 1'b0;
    do_release = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          do_load    = 1'b1;
          sel_lane   = '0;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (ofm_ready) begin
          if (lane_reg != LAST_LANE) begin
            do_advance = 1'b1;
            sel_lane   = lane_reg + 1'b1;
          end else begin
            do_release = 1'b1;
            if (full_reg[~rd_bank_reg]) begin
              do_load  = 1'b1;
              sel_bank = ~rd_bank_reg;
              sel_lane = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      full_reg       <= '0;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      lane_reg       <= '0;
      tile_reg       <= '0;
      ofm_reg        <= '0;
      ofm_valid_reg  <= 1'b0;
      tile_done_reg  <= 1'b0;
      layer_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (clear) begin
      state_reg      <= ST_IDLE;
      full_reg       <= '0;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      lane_reg       <= '0;
      tile_reg       <= '0;
      ofm_reg        <= '0;
      ofm_valid_reg  <= 1'b0;
      tile_done_reg  <= 1'b0;
      layer_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tile_done_reg  <= 1'b0;
      layer_done_reg <= 1'b0;
      if (set_output) begin
        if (capture_ready) begin
          full_reg[wr_bank_reg] <= 1'b1;
          wr_bank_reg           <= ~wr_bank_reg;
        end else begin
          overrun_reg <= 1'b1;
        end
      end
      // The capture bank is always the empty one, so a same-cycle release never collides with it.
      if (do_release) begin
        full_reg[rd_bank_reg] <= 1'b0;
        rd_bank_reg           <= ~rd_bank_reg;
        tile_done_reg         <= 1'b1;
        if (tile_reg == LAST_TILE) begin
          tile_reg       <= '0;
          layer_done_reg <= 1'b1;
        end else begin
          tile_reg <= tile_reg + 1'b1;
        end
      end
      if (do_load || do_advance) begin
        ofm_reg       <= rq_result;
        lane_reg      <= sel_lane;
        ofm_valid_reg <= 1'b1;
      end else if (do_release) begin
        ofm_valid_reg <= 1'b0;
        lane_reg      <= '0;
      end
    end
  end

  assign ofm        = ofm_reg;
  assign ofm_valid  = ofm_valid_reg;
  assign lane_idx   = lane_reg;
  assign tile_done  = tile_done_reg;
  assign layer_done = layer_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fc_tile_drain.sv
// Directed bench for fc_tile_drain: capture, requant corner cases, backpressure, ping-pong, clear and reset.
module tb_fc_tile_drain;

  localparam int PW = 24;
  localparam int DW = 16;
  localparam int BW = 16;
  localparam int TS = 8;
  localparam int NT = 4;
  localparam int SW = 5;

  logic            clk2 = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            set_output = 1'b0;
  logic [TS*PW-1:0] psum = '0;
  logic [TS*BW-1:0] bias = '0;
  logic [SW-1:0]   shift = '0;
  logic            relu_en = 1'b0;
  logic            capture_ready;
  logic [DW-1:0]   ofm;
  logic            ofm_valid;
  logic            ofm_ready = 1'b0;
  logic [2:0]      lane_idx;
  logic            tile_done;
  logic            layer_done;
  logic            overrun;

  int checks = 0;
  int errors = 0;
  int tiles_done = 0;
  int pv[8];
  int bv[8];
  int exp_v[8];

  fc_tile_drain #(
    .PSUM_WIDTH  (PW),
    .DATA_WIDTH  (DW),
    .BIAS_WIDTH  (BW),
    .TILING_SIZE (TS),
    .NUM_TILES   (NT),
    .SHIFT_WIDTH (SW),
    .RELU        (2)
  ) dut (
    .clk2          (clk2),
    .rst_n         (rst_n),
    .clear         (clear),
    .set_output    (set_output),
    .psum          (psum),
    .bias          (bias),
    .shift         (shift),
    .relu_en       (relu_en),
    .capture_ready (capture_ready),
    .ofm           (ofm),
    .ofm_valid     (ofm_valid),
    .ofm_ready     (ofm_ready),
    .lane_idx      (lane_idx),
    .tile_done     (tile_done),
    .layer_done    (layer_done),
    .overrun       (overrun)
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_tile();
    for (int i = 0; i < TS; i++) begin
      psum[i*PW +: PW] = PW'(pv[i]);
      bias[i*BW +: BW] = BW'(bv[i]);
    end
  endtask

  task automatic capture();
    load_tile();
    set_output = 1'b1;
    tick();
    set_output = 1'b0;
  endtask

  // Expects ofm_valid already high with lane 0; stall_mask bit i holds lane i for two cycles.
  task automatic drain(input string tag, input logic [7:0] stall_mask);
    ofm_ready = 1'b1;
    for (int i = 0; i < TS; i++) begin
      chk($sformatf("%s valid[%0d]", tag, i), ofm_valid, 1);
      chk($sformatf("%s ofm[%0d]", tag, i), $signed(ofm), exp_v[i]);
      chk($sformatf("%s lane[%0d]", tag, i), lane_idx, i);
      if (stall_mask[i]) begin
        ofm_ready = 1'b0;
        repeat (2) begin
          tick();
          chk($sformatf("%s hold_ofm[%0d]", tag, i), $signed(ofm), exp_v[i]);
          chk($sformatf("%s hold_lane[%0d]", tag, i), lane_idx, i);
          chk($sformatf("%s hold_valid[%0d]", tag, i), ofm_valid, 1);
        end
        ofm_ready = 1'b1;
      end
      tick();
    end
    tiles_done++;
    chk({tag, " tile_done"}, tile_done, 1);
    chk({tag, " layer_done"}, layer_done, (tiles_done % NT == 0) ? 1 : 0);
  endtask

  initial begin
    repeat (3) @(posedge clk2);
    #1;
    chk("rst ofm", ofm, 0);
    chk("rst ofm_valid", ofm_valid, 0);
    chk("rst lane_idx", lane_idx, 0);
    chk("rst tile_done", tile_done, 0);
    chk("rst layer_done", layer_done, 0);
    chk("rst overrun", overrun, 0);
    chk("rst capture_ready", capture_ready, 1);
    rst_n = 1'b1;
    tick();

    // Basic tile: 100*i + 1 with ReLU on
    relu_en = 1'b1; shift = '0; ofm_ready = 1'b1;
    for (int i = 0; i < TS; i++) begin pv[i] = 100 * i; bv[i] = 1; exp_v[i] = 100 * i + 1; end
    capture();
    chk("latency valid_low", ofm_valid, 0);
    tick();
    drain("basic", 8'h00);
    chk("basic idle valid", ofm_valid, 0);
    chk("basic capture_ready", capture_ready, 1);

    // Rounding with shift=1, ReLU off
    relu_en = 1'b0; shift = 5'd1;
    pv = '{-7, 8388607, -8388608, 5, 6, -5, -1, 65533};
    bv = '{0, 0, 0, 0, 0, 0, -1, 0};
    exp_v = '{-3, 32767, -32768, 3, 3, -2, -1, 32767};
    capture(); tick();
    drain("round", 8'h00);

    // Saturation with shift=0
    shift = '0;
    pv = '{8388607, -8388608, 100, 32767, -32768, -32769, 0, 1234};
    bv = '{0, -1, -200, 1, 0, 0, 0, -34};
    exp_v = '{32767, -32768, -100, 32767, -32768, -32768, 0, 1200};
    capture(); tick();
    drain("sat", 8'h00);

    // ReLU at runtime; fourth tile since reset, so layer_done fires on beat 32
    relu_en = 1'b1;
    for (int i = 0; i < TS; i++) begin pv[i] = (i - 4) * 10; bv[i] = 0; exp_v[i] = (i > 4) ? (i - 4) * 10 : 0; end
    capture(); tick();
    drain("relu", 8'h00);

    // Backpressure stalls on lanes 0, 2 and 7
    relu_en = 1'b0;
    for (int i = 0; i < TS; i++) begin pv[i] = 3 * i + 1; bv[i] = 0; exp_v[i] = 3 * i + 1; end
    capture(); tick();
    drain("bp", 8'b1000_0101);

    // Ping-pong: two captures fill both banks, third is dropped
    ofm_ready = 1'b0;
    for (int i = 0; i < TS; i++) begin pv[i] = i + 10; bv[i] = 0; end
    load_tile();
    set_output = 1'b1;
    tick();
    for (int i = 0; i < TS; i++) pv[i] = 7 * i - 3;
    load_tile();
    tick();
    set_output = 1'b0;
    chk("pp capture_ready full", capture_ready, 0);
    chk("pp overrun before", overrun, 0);
    for (int i = 0; i < TS; i++) pv[i] = 999;
    capture();
    chk("pp overrun set", overrun, 1);
    chk("pp capture_ready still", capture_ready, 0);
    for (int i = 0; i < TS; i++) exp_v[i] = i + 10;
    drain("pingA", 8'h00);
    for (int i = 0; i < TS; i++) exp_v[i] = 7 * i - 3;
    drain("pingB", 8'h00);
    chk("pp dropped valid", ofm_valid, 0);
    chk("pp capture_ready free", capture_ready, 1);
    chk("pp overrun sticky", overrun, 1);

    // Clear at beat 3
    for (int i = 0; i < TS; i++) begin pv[i] = 2 * i; bv[i] = 0; end
    capture();
    repeat (4) tick();
    chk("clr at lane", lane_idx, 3);
    chk("clr at ofm", $signed(ofm), 6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tiles_done = 0;
    chk("clr ofm_valid", ofm_valid, 0);
    chk("clr capture_ready", capture_ready, 1);
    chk("clr overrun", overrun, 0);
    chk("clr lane_idx", lane_idx, 0);
    tick();
    chk("clr stays idle", ofm_valid, 0);
    for (int i = 0; i < TS; i++) begin pv[i] = 500 - i; exp_v[i] = 500 - i; end
    capture(); tick();
    drain("restart", 8'h00);

    // Asynchronous reset mid-stream
    ofm_ready = 1'b0;
    for (int i = 0; i < TS; i++) pv[i] = i + 1;
    capture(); tick();
    chk("arst pre valid", ofm_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst ofm_valid", ofm_valid, 0);
    chk("arst lane_idx", lane_idx, 0);
    chk("arst ofm", ofm, 0);
    chk("arst capture_ready", capture_ready, 1);
    rst_n = 1'b1;
    tick(); tick();
    chk("arst no resume", ofm_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
